// File: rtl/pc_seq_if.sv
// Handshake bundle between the PC sequencer and its neighbours: hazard unit,
// EX-stage branch logic, interrupt pin and the vector/stack memory port.
interface pc_seq_if;
    logic        int_req;
    logic        branch_req;
    logic        hazard_stall;
    logic        mem_ready;
    logic [1:0]  pc_sel;
    logic        pc_en;
    logic        flush;
    logic        save_push;
    logic        vec_rd;
    logic [31:0] vec_addr;
    logic        int_ack;
    logic        busy;
    logic        err;

    modport master (
        output int_req, branch_req, hazard_stall, mem_ready,
        input  pc_sel, pc_en, flush, save_push, vec_rd, vec_addr, int_ack, busy, err
    );

    modport slave (
        input  int_req, branch_req, hazard_stall, mem_ready,
        output pc_sel, pc_en, flush, save_push, vec_rd, vec_addr, int_ack, busy, err
    );
endinterface

// File: rtl/pc_sequencer.sv
// PC source/enable control: reset-vector boot, fetch/branch/stall arbitration
// and the flush -> return-PC push -> vector fetch interrupt entry.
module pc_sequencer #(
    parameter logic [31:0] RESET_VEC_ADDR = 32'h0000_0000,
    parameter logic [31:0] INT_VEC_ADDR   = 32'h0000_0002,
    parameter int          TIMEOUT_CYCLES = 16
) (
    input  logic     clk,
    input  logic     rst,
    pc_seq_if.slave  bus
);
    localparam int            CW  = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] TMO = CW'(TIMEOUT_CYCLES);

    localparam logic [2:0] ST_BOOT      = 3'd0;
    localparam logic [2:0] ST_RUN       = 3'd1;
    localparam logic [2:0] ST_INT_FLUSH = 3'd2;
    localparam logic [2:0] ST_INT_PUSH  = 3'd3;
    localparam logic [2:0] ST_INT_VEC   = 3'd4;

    logic [2:0]    state_q, state_d;
    logic          int_pending_q, int_pending_d;
    logic          int_req_dly_q, int_req_dly_d;
    logic          armed_q, armed_d;
    logic [CW-1:0] wait_cnt_q, wait_cnt_d;
    logic          err_q, err_d;

    logic [1:0]    pc_sel_c;
    logic          pc_en_c, flush_c, save_push_c, vec_rd_c, int_ack_c;
    logic [31:0]   vec_addr_c;
    logic          int_edge, waiting;

    always_comb begin
        state_d     = state_q;
        pc_sel_c    = 2'b00;
        pc_en_c     = 1'b0;
        flush_c     = 1'b0;
        save_push_c = 1'b0;
        vec_rd_c    = 1'b0;
        vec_addr_c  = 32'h0;
        int_ack_c   = 1'b0;
        case (state_q)
            ST_BOOT: begin
                vec_rd_c   = 1'b1;
                vec_addr_c = RESET_VEC_ADDR;
                if (bus.mem_ready) begin
                    pc_sel_c = 2'b01;
                    pc_en_c  = 1'b1;
                    state_d  = ST_RUN;
                end
            end
            ST_RUN: begin
                // Branch beats a pending interrupt so the pushed return PC is the target.
                if (bus.hazard_stall) begin
                    pc_en_c = 1'b0;
                end else if (bus.branch_req) begin
                    pc_sel_c = 2'b11;
                    pc_en_c  = 1'b1;
                    flush_c  = 1'b1;
                end else if (int_pending_q) begin
                    state_d = ST_INT_FLUSH;
                end else begin
                    pc_en_c = 1'b1;
                end
            end
            ST_INT_FLUSH: begin
                flush_c = 1'b1;
                state_d = ST_INT_PUSH;
            end
            ST_INT_PUSH: begin
                save_push_c = 1'b1;
                if (bus.mem_ready) state_d = ST_INT_VEC;
            end
            ST_INT_VEC: begin
                vec_rd_c   = 1'b1;
                vec_addr_c = INT_VEC_ADDR;
                if (bus.mem_ready) begin
                    pc_sel_c  = 2'b10;
                    pc_en_c   = 1'b1;
                    int_ack_c = 1'b1;
                    state_d   = ST_RUN;
                end
            end
            default: state_d = ST_BOOT;
        endcase
    end

    // armed_q masks the first post-reset cycle so a level held through reset is no edge.
    always_comb begin
        int_req_dly_d = bus.int_req;
        armed_d       = 1'b1;
        int_edge      = armed_q & bus.int_req & ~int_req_dly_q;
        int_pending_d = int_edge | (int_pending_q & ~int_ack_c);
        waiting       = (state_q == ST_BOOT) || (state_q == ST_INT_PUSH) || (state_q == ST_INT_VEC);
        if ((state_d != state_q) || bus.mem_ready)
            wait_cnt_d = '0;
        else if (waiting && (wait_cnt_q != TMO))
            wait_cnt_d = wait_cnt_q + CW'(1);
        else
            wait_cnt_d = wait_cnt_q;
        err_d = err_q | (wait_cnt_d == TMO);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= ST_BOOT;
            int_pending_q <= 1'b0;
            int_req_dly_q <= 1'b0;
            armed_q       <= 1'b0;
            wait_cnt_q    <= '0;
            err_q         <= 1'b0;
        end else begin
            state_q       <= state_d;
            int_pending_q <= int_pending_d;
            int_req_dly_q <= int_req_dly_d;
            armed_q       <= armed_d;
            wait_cnt_q    <= wait_cnt_d;
            err_q         <= err_d;
        end
    end

    assign bus.pc_sel    = rst ? 2'b00 : pc_sel_c;
    assign bus.pc_en     = ~rst & pc_en_c;
    assign bus.flush     = ~rst & flush_c;
    assign bus.save_push = ~rst & save_push_c;
    assign bus.vec_rd    = ~rst & vec_rd_c;
    assign bus.vec_addr  = rst ? 32'h0 : vec_addr_c;
    assign bus.int_ack   = ~rst & int_ack_c;
    assign bus.busy      = ~rst & (state_q != ST_RUN);
    assign bus.err       = ~rst & err_q;
endmodule
